// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, MF select, FSM states.
package hilo_pkg;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [1:0] MF_NONE = 2'b00;
  localparam logic [1:0] MF_HI   = 2'b10;
  localparam logic [1:0] MF_LO   = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_MUL  = 2'd1;
  localparam state_t S_DIV  = 2'd2;
  localparam state_t S_FIX  = 2'd3;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// EX-stage request / MF read / status bundle between the core and the HI/LO unit.
interface hilo_muldiv_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [1:0]       mf_sel;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (output start, op, src_a, src_b, mf_sel,
                  input  out, busy, done, div_by_zero);
  modport slave  (input  start, op, src_a, src_b, mf_sel,
                  output out, busy, done, div_by_zero);
endinterface

// File: rtl/hilo_muldiv_unit_seq_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, done pulses after WIDTH iterations.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d, done_q, done_d;
  logic [WIDTH:0]   shifted;
  logic             ge;

  // The dividend drains out of quo_q from the top as quotient bits fill in from the bottom.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign ge      = shifted >= {1'b0, dvs_q};

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (start) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      quo_d = {quo_q[WIDTH-2:0], ge};
      rem_d = ge ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH-1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = done_q;
endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit: fixed-latency multiply, iterative divide with sign fix-up, MTHI/MTLO.
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 4
) (
  input logic clk,
  input logic reset,
  hilo_muldiv_unit_if.slave bus
);
  localparam int MAXC  = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
  logic             sgn_q, sgn_d, done_q, done_d, dbz_q, dbz_d;

  logic             sgn_in, dv_start, dv_done;
  logic [WIDTH-1:0] dvd_mag, dvs_mag, dv_quo, dv_rem, q_fix, r_fix;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;

  assign sgn_in   = is_signed_op(bus.op);
  assign dvd_mag  = (sgn_in && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
  assign dvs_mag  = (sgn_in && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;
  assign dv_start = (state_q == S_IDLE) && bus.start &&
                    (bus.op == OP_DIV || bus.op == OP_DIVU);

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (dv_start),
    .dividend  (dvd_mag),
    .divisor   (dvs_mag),
    .quotient  (dv_quo),
    .remainder (dv_rem),
    .done      (dv_done)
  );

  // Extending to 2*WIDTH first makes one modular multiply serve both signed and unsigned.
  assign a_ext = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign b_ext = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign prod  = a_ext * b_ext;

  // Most-negative / -1 falls out naturally: negating 2^(WIDTH-1) wraps to itself.
  assign q_fix = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -dv_quo : dv_quo;
  assign r_fix = (sgn_q && a_q[WIDTH-1]) ? -dv_rem : dv_rem;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start) begin
        case (bus.op)
          OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
            state_d = (bus.op == OP_MULT || bus.op == OP_MULTU) ? S_MUL : S_DIV;
            cnt_d   = CNT_W'(1);
            a_d     = bus.src_a;
            b_d     = bus.src_b;
            sgn_d   = sgn_in;
          end
          OP_MTHI: hi_d = bus.src_a;
          OP_MTLO: lo_d = bus.src_a;
          OP_NOP:  ;
          default: ;
        endcase
      end
      S_MUL: begin
        if (cnt_q == CNT_W'(MUL_CYCLES)) begin
          {hi_d, lo_d} = prod;
          done_d       = 1'b1;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DIV: begin
        if (cnt_q == CNT_W'(WIDTH)) state_d = S_FIX;
        else                         cnt_d   = cnt_q + CNT_W'(1);
      end
      S_FIX: if (dv_done) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (b_q == '0) begin
          hi_d  = a_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          hi_d = r_fix;
          lo_d = q_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    case (bus.mf_sel)
      MF_NONE: bus.out = '0;
      MF_HI:   bus.out = hi_q;
      MF_LO:   bus.out = lo_q;
      default: bus.out = '0;
    endcase
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: arithmetic reference model checked every cycle plus literal pins.
module tb_hilo_muldiv_unit;
  localparam int W  = 32;
  localparam int MC = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hilo_muldiv_unit_if #(.WIDTH(W)) bus ();
  hilo_muldiv_unit #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: results from plain integer arithmetic, committed after the busy window.
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  logic         m_done, m_dbz, p_dbz;
  int           m_rem;
  logic         chk_en = 1'b0;

  always @(posedge clk) begin
    logic [2*W-1:0] pr;
    int sa, sb;
    if (reset) begin
      m_hi = '0; m_lo = '0; m_done = 0; m_dbz = 0; m_rem = 0;
    end else begin
      m_done = 0; m_dbz = 0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1; m_dbz = p_dbz;
        end
      end else if (bus.start) begin
        sa = $signed(bus.src_a);
        sb = $signed(bus.src_b);
        p_dbz = 0;
        case (bus.op)
          3'b001: begin
            pr = 64'(longint'(sa) * longint'(sb));
            {p_hi, p_lo} = pr; m_rem = MC;
          end
          3'b010: begin
            pr = {32'b0, bus.src_a} * {32'b0, bus.src_b};
            {p_hi, p_lo} = pr; m_rem = MC;
          end
          3'b011: begin
            m_rem = W + 1;
            if (sb == 0) begin p_lo = '1; p_hi = bus.src_a; p_dbz = 1; end
            else if (bus.src_a == 32'h8000_0000 && sb == -1) begin p_lo = 32'h8000_0000; p_hi = 0; end
            else begin p_lo = sa / sb; p_hi = sa % sb; end
          end
          3'b100: begin
            m_rem = W + 1;
            if (bus.src_b == 0) begin p_lo = '1; p_hi = bus.src_a; p_dbz = 1; end
            else begin p_lo = bus.src_a / bus.src_b; p_hi = bus.src_a % bus.src_b; end
          end
          3'b101: m_hi = bus.src_a;
          3'b110: m_lo = bus.src_a;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    logic [W-1:0] exp_out;
    if (chk_en) begin
      exp_out = (bus.mf_sel == 2'b10) ? m_hi : (bus.mf_sel == 2'b11) ? m_lo : '0;
      chk("model_busy", W'(bus.busy), W'(m_rem > 0));
      chk("model_done", W'(bus.done), W'(m_done));
      chk("model_dbz",  W'(bus.div_by_zero), W'(m_dbz));
      chk("model_out",  bus.out, exp_out);
    end
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1; bus.op = o; bus.src_a = a; bus.src_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 3'b000;
    bus.src_a = $urandom; bus.src_b = $urandom;
  endtask

  // Returns at the falling edge of the done cycle; nb counts busy cycles seen on the way.
  task automatic wait_done(output int nb, output logic dz);
    nb = 0; dz = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.done) begin dz = bus.div_by_zero; return; end
      if (bus.busy) nb++;
    end
    chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic rd(input string nm, input logic [1:0] sel, input logic [W-1:0] exp);
    bus.mf_sel = sel; #1;
    chk(nm, bus.out, exp);
  endtask

  int nb;
  logic dz;

  initial begin
    bus.start = 0; bus.op = 0; bus.src_a = 0; bus.src_b = 0; bus.mf_sel = 2'b00;
    repeat (2) @(posedge clk);
    #1 reset = 0; chk_en = 1;
    @(negedge clk);
    rd("rst_hi", 2'b10, 32'h0);
    rd("rst_lo", 2'b11, 32'h0);
    chk("rst_busy", W'(bus.busy), 32'd0);
    @(posedge clk); #1;

    // MULTU max*max; out keeps old LO while busy
    issue(3'b110, 32'h0000_5555, 32'h0);
    bus.mf_sel = 2'b11;
    issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("old_lo_busy", bus.out, 32'h0000_5555);
    wait_done(nb, dz);
    chk("multu_busy_cyc", nb + 1, 32'd4);
    rd("multu_hi", 2'b10, 32'hFFFF_FFFE);
    rd("multu_lo", 2'b11, 32'h0000_0001);

    issue(3'b001, 32'hFFFF_FFFD, 32'd7);
    wait_done(nb, dz);
    rd("mult_hi", 2'b10, 32'hFFFF_FFFF);
    rd("mult_lo", 2'b11, 32'hFFFF_FFEB);

    issue(3'b011, 32'hFFFF_FFF9, 32'd2);
    wait_done(nb, dz);
    chk("div_busy_cyc", nb, 32'd33);
    rd("div_lo", 2'b11, 32'hFFFF_FFFD);
    rd("div_hi", 2'b10, 32'hFFFF_FFFF);

    issue(3'b100, 32'd100, 32'd7);
    wait_done(nb, dz);
    rd("divu_lo", 2'b11, 32'd14);
    rd("divu_hi", 2'b10, 32'd2);

    issue(3'b100, 32'd5, 32'd0);
    wait_done(nb, dz);
    chk("dbz_flag", W'(dz), 32'd1);
    rd("dbz_lo", 2'b11, 32'hFFFF_FFFF);
    rd("dbz_hi", 2'b10, 32'd5);

    issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(nb, dz);
    chk("ovf_flag", W'(dz), 32'd0);
    rd("ovf_lo", 2'b11, 32'h8000_0000);
    rd("ovf_hi", 2'b10, 32'h0);

    // Reset in the third busy cycle of a divide
    @(posedge clk); #1;
    issue(3'b011, 32'd1000, 32'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_busy", W'(bus.busy), 32'd1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("abort_busy", W'(bus.busy), 32'd0);
    rd("abort_hi", 2'b10, 32'h0);
    rd("abort_lo", 2'b11, 32'h0);

    // MTHI ignored while busy; MTLO and MULT accepted in the done cycle
    @(posedge clk); #1;
    issue(3'b001, 32'd3, 32'd5);
    issue(3'b101, 32'h1234, 32'h0);
    wait_done(nb, dz);
    issue(3'b110, 32'hABCD, 32'h0);
    rd("mtlo_done_cyc", 2'b11, 32'hABCD);
    rd("mthi_ignored", 2'b10, 32'h0);
    @(negedge clk);
    issue(3'b001, 32'd2, 32'd3);
    wait_done(nb, dz);
    rd("b2b_lo1", 2'b11, 32'd6);
    issue(3'b001, 32'd4, 32'd5);
    @(negedge clk);
    chk("b2b_busy", W'(bus.busy), 32'd1);
    wait_done(nb, dz);
    rd("b2b_lo2", 2'b11, 32'd20);
    rd("b2b_hi2", 2'b10, 32'd0);

    repeat (2) @(posedge clk);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Parametrised HI/LO multiply/divide unit for the pipelined MIPS core; successor to the single-cycle combinational HI/LO block.
- Multiplies in a fixed number of cycles and divides iteratively over WIDTH+1 cycles.
- Supports signed and unsigned modes, plus MTHI/MTLO writes.
- Exposes busy/done so the hazard unit stalls MFHI/MFLO and new mult/div ops until the result is committed.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- MUL_CYCLES, 4, busy cycles for a multiply (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  op request from EX stage; qualified by op.
- op  in  3  000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; others are NOP.
- src_a  in  WIDTH  rs operand: multiplicand / dividend / MT data.
- src_b  in  WIDTH  rt operand: multiplier / divisor.
- mf_sel  in  2  00 none, 10 MFHI, 11 MFLO, 01 reserved (reads as none).
- out  out  WIDTH  combinational: HI, LO or 0 per mf_sel.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse when HI/LO commit from mult/div.
- div_by_zero  out  1  one-cycle pulse with done when the divisor was 0.

Behaviour:
- Reset, checked at a clock edge: HI=0, LO=0, busy=0, done=0, div_by_zero=0, state=IDLE.
  - Reset mid-operation aborts the op; no commit occurs.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE→MUL on a MULT/MULTU start.
  - IDLE→DIV on a DIV/DIVU start.
  - MUL→IDLE when the count reaches MUL_CYCLES.
  - DIV→FIX after WIDTH iterations.
  - FIX→IDLE after one cycle.
- Accept rule: start is accepted only when busy=0. start while busy=1 is ignored, including MTHI/MTLO; the hazard unit must stall.
- MTHI/MTLO: write src_a into HI or LO at the accepting edge. busy stays 0; done stays 0.
- Operand capture: operands and sign mode are latched at the accepting edge. Later changes on src_a/src_b have no effect.
- Multiply:
  - busy is high for exactly MUL_CYCLES cycles.
  - At the last edge {HI,LO} = the 2*WIDTH-bit product, signed (MULT) or unsigned (MULTU). busy falls and done=1 for the next cycle.
- Divide:
  - Restoring shift-subtract on magnitudes, one quotient bit per cycle for WIDTH cycles.
  - FIX cycle applies signs: quotient negated if the operand signs differ; remainder takes the sign of the dividend.
  - busy is high for WIDTH+1 cycles. Then LO = quotient, HI = remainder, done pulses.
- Divide by zero: LO = all ones, HI = dividend (raw src_a). div_by_zero pulses with done; no other side effect.
- Signed overflow (DIV with most-negative / -1): LO = most-negative value, HI = 0. No flag.
- out:
  - Purely combinational from the current HI/LO registers; returns the old value while busy.
  - A result committed at edge T is visible on out in the cycle after T.
- done and start in the same cycle: the new op is accepted (busy is already 0).
- Back-to-back ops: there are zero idle cycles between the done cycle and the next accepted start.

Decomposition:
- hilo_pkg holds:
  - op encodings (OP_NOP…OP_MTLO);
  - mf_sel encodings (MF_NONE, MF_HI, MF_LO);
  - the state enum (S_IDLE, S_MUL, S_DIV, S_FIX).
- Sub-module seq_divider(WIDTH): magnitude restoring divider with start/done, quotient and remainder outputs.
  - The top block does sign handling, the multiply counter, HI/LO registers and the out mux.

Test Plan:
- Reset then mf_sel=10 and 11 → out=0 both. Assert reset in the 3rd busy cycle of a DIV → busy=0 next cycle; HI=LO=0.
- MULTU 0xFFFFFFFF×0xFFFFFFFF, MUL_CYCLES=4 → busy high 4 cycles, done pulse. Then HI=0xFFFFFFFE, LO=0x00000001; out shows the old LO while busy.
- MULT 0xFFFFFFFD(-3)×7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV 0xFFFFFFF9(-7)/2 → busy 33 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 → LO=14, HI=2.
- DIVU 5/0 → LO=0xFFFFFFFF, HI=5, div_by_zero=1 with done. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0, no flag.
- MTHI 0x1234 while busy → ignored; MTLO 0xABCD in the done cycle → accepted, LO=0xABCD next cycle. MULT start in the done cycle → accepted, busy stays high.
